// File: rtl/uart_tx_arb.sv
// Round-robin transmit arbiter: polls the UART status register until tx is idle,
// then writes one byte to the data register. Define UART_TX_ARB_LOCK_EN for message locking.
module uart_tx_arb #(
    parameter int unsigned N_REQ       = 2,
    parameter logic [7:0]  USR_ADDR    = 8'h04,
    parameter logic [7:0]  UDR_ADDR    = 8'h08,
    parameter int unsigned TX_BUSY_BIT = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o,
    output logic [7:0]         addr_o,
    output logic [31:0]        data_o,
    input  logic [31:0]        data_i,
    output logic               we_o,
    output logic               stb_o,
    input  logic               ack_i
);
    localparam int unsigned      IDX_W    = $clog2(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RD_USR = 2'd1,
        S_RD_GAP = 2'd2,
        S_WR_UDR = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] gnt_next;
    logic [IDX_W-1:0] sel;
    logic             sel_vld;
    logic [7:0]       byte_q, byte_d;
    logic             tx_busy_q, tx_busy_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             busy_q, busy_d;
    logic             stb_q, stb_d;
    logic             we_q, we_d;
    logic [7:0]       addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [7:0]       req_byte [N_REQ];
    logic             unused_in;
`ifdef UART_TX_ARB_LOCK_EN
    logic             lock_q, lock_d;
    logic             last_q, last_d;

    assign unused_in = ^data_i;
`else
    assign unused_in = ^{req_last_i, data_i};
`endif

    always_comb begin : unpack_bytes
        for (int unsigned k = 0; k < N_REQ; k++) begin
            req_byte[k] = req_data_i[8*k +: 8];
        end
    end

    // First valid requester at or after the pointer; a held lock overrides rotation.
    always_comb begin : rr_select
        logic [IDX_W:0] idx;
        idx     = '0;
        sel     = '0;
        sel_vld = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (IDX_W+1)'(ptr_q) + (IDX_W+1)'(i);
            if (idx >= (IDX_W+1)'(N_REQ)) begin
                idx = idx - (IDX_W+1)'(N_REQ);
            end
            if (!sel_vld && req_valid_i[idx[IDX_W-1:0]]) begin
                sel     = idx[IDX_W-1:0];
                sel_vld = 1'b1;
            end
        end
`ifdef UART_TX_ARB_LOCK_EN
        if (lock_q) begin
            sel     = gnt_idx_q;
            sel_vld = req_valid_i[gnt_idx_q];
        end
`endif
    end

    assign gnt_next    = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + IDX_W'(1);
    assign req_ready_o = (rst_ni && state_q == S_IDLE && sel_vld) ? (N_REQ'(1) << sel) : '0;

    always_ff @(posedge clk_i) begin : state_reg
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            byte_q    <= '0;
            tx_busy_q <= 1'b0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q    <= 1'b0;
            last_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            byte_q    <= byte_d;
            tx_busy_q <= tx_busy_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q    <= lock_d;
            last_q    <= last_d;
`endif
        end
    end

    always_comb begin : next_state
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        byte_d    = byte_q;
        tx_busy_d = tx_busy_q;
        grant_d   = grant_q;
`ifdef UART_TX_ARB_LOCK_EN
        lock_d    = lock_q;
        last_d    = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sel_vld) begin
                    byte_d    = req_byte[sel];
                    gnt_idx_d = sel;
                    grant_d   = N_REQ'(1) << sel;
                    state_d   = S_RD_USR;
`ifdef UART_TX_ARB_LOCK_EN
                    last_d    = req_last_i[sel];
`endif
                end
            end
            S_RD_USR: begin
                if (ack_i) begin
                    tx_busy_d = data_i[TX_BUSY_BIT];
                    state_d   = S_RD_GAP;
                end
            end
            S_RD_GAP: begin
                state_d = tx_busy_q ? S_RD_USR : S_WR_UDR;
            end
            S_WR_UDR: begin
                if (ack_i) begin
                    state_d = S_IDLE;
                    grant_d = '0;
`ifdef UART_TX_ARB_LOCK_EN
                    // Mid-message bytes keep ownership; the final byte releases it.
                    if (last_q) begin
                        lock_d = 1'b0;
                        ptr_d  = gnt_next;
                    end else begin
                        lock_d = 1'b1;
                    end
`else
                    ptr_d = gnt_next;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they leave flops aligned with it.
    always_comb begin : output_dec
        stb_d  = 1'b0;
        we_d   = 1'b0;
        addr_d = '0;
        data_d = '0;
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_RD_USR: begin
                stb_d  = 1'b1;
                addr_d = USR_ADDR;
            end
            S_WR_UDR: begin
                stb_d  = 1'b1;
                we_d   = 1'b1;
                addr_d = UDR_ADDR;
                data_d = {24'h0, byte_d};
            end
            default: ;
        endcase
    end

    assign grant_o = grant_q;
    assign busy_o  = busy_q;
    assign stb_o   = stb_q;
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized bench for uart_tx_arb: a transaction-level arbitration/bus model plus a
// Wishbone slave stub that answers status reads with a chosen tx-busy flag.
module tb_uart_tx_arb;
    localparam int N = 2;

    logic           clk         = 1'b0;
    logic           rst_ni      = 1'b0;
    logic [N-1:0]   req_valid_i = '0;
    logic [8*N-1:0] req_data_i  = '0;
    logic [N-1:0]   req_last_i  = '0;
    logic [N-1:0]   req_ready_o;
    logic [N-1:0]   grant_o;
    logic           busy_o;
    logic [7:0]     addr_o;
    logic [31:0]    data_o;
    logic [31:0]    data_i      = '0;
    logic           we_o;
    logic           stb_o;
    logic           ack_i       = 1'b0;

    uart_tx_arb #(.N_REQ(N)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .addr_o      (addr_o),
        .data_o      (data_o),
        .data_i      (data_i),
        .we_o        (we_o),
        .stb_o       (stb_o),
        .ack_i       (ack_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       last;
        logic [7:0] b;
    } item_t;

    item_t rq [N][$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;

    int    gate_pct = 100;
    int    busy_pct = 0;
    int    max_wait = 0;
    bit    rst_now  = 1'b0;
    int    busy_q[$];

    bit    m_active = 1'b0;
    bit    m_lock   = 1'b0;
    bit    m_wr     = 1'b0;
    bit    m_stb    = 1'b0;
    bit    m_gap    = 1'b0;
    int    m_ptr    = 0;
    int    m_lock_idx = 0;
    int    m_gidx   = 0;
    item_t m_item;

    int    s_cnt = 0;
    int    s_wait = 0;
    bit    stb_prev = 1'b0;
    bit    ack_prev = 1'b0;
    bit    busy_prev = 1'b0;

    int         wlog[$];
    logic [7:0] blog[$];
    int         rdy_cnt[N];
    int         last_len = 0;
    int         last_reads = 0;
    int         b_start = 0;
    int         reads = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs, compare outputs with the model, then advance the model.
    task automatic tick();
        logic [N-1:0] vld;
        logic [N-1:0] exp_rdy;
        logic         e_we;
        logic [7:0]   e_addr;
        logic [31:0]  e_data;
        bit           busy_rsp;
        bit           ack;
        int           sel;
        int           c;
        @(posedge clk);
        #1;
        cyc++;
        busy_rsp = 1'b0;
        if (stb_o && (!stb_prev || ack_prev)) begin
            s_cnt  = 0;
            s_wait = int'($urandom_range(max_wait, 0));
        end else if (stb_o) begin
            s_cnt++;
        end
        ack = stb_o && (s_cnt == s_wait + 1);
        if (ack && !m_wr) begin
            if (busy_q.size() > 0) busy_rsp = (busy_q.pop_front() != 0);
            else busy_rsp = (int'($urandom_range(99, 0)) < busy_pct);
        end
        data_i    = $urandom();
        data_i[3] = busy_rsp;
        ack_i     = ack;
        for (int k = 0; k < N; k++) begin
            vld[k] = (rq[k].size() > 0) && (int'($urandom_range(99, 0)) < gate_pct);
            req_valid_i[k] = vld[k];
            req_data_i[8*k +: 8] = (rq[k].size() > 0) ? rq[k][0].b : 8'($urandom());
            req_last_i[k] = (rq[k].size() > 0) ? rq[k][0].last : 1'($urandom());
        end
        rst_ni = !rst_now;
        #1;

        sel = -1;
        if (!m_active && !rst_now) begin
            if (m_lock) begin
                if (vld[m_lock_idx]) sel = m_lock_idx;
            end else begin
                for (int j = 0; j < N; j++) begin
                    c = (m_ptr + j) % N;
                    if (sel < 0 && vld[c]) sel = c;
                end
            end
        end
        exp_rdy = (sel >= 0) ? (N'(1) << sel) : '0;
        e_we   = m_stb && m_wr;
        e_addr = m_stb ? (m_wr ? 8'h08 : 8'h04) : 8'h00;
        e_data = (m_stb && m_wr) ? {24'h0, m_item.b} : 32'h0;
        check_eq("ready", 64'(req_ready_o), 64'(exp_rdy));
        check_eq("busy", 64'(busy_o), 64'(m_active));
        check_eq("grant", 64'(grant_o), m_active ? 64'(N'(1) << m_gidx) : 64'h0);
        check_eq("stb", 64'(stb_o), 64'(m_stb));
        check_eq("bus", 64'({we_o, addr_o, data_o}), 64'({e_we, e_addr, e_data}));

        for (int k = 0; k < N; k++) rdy_cnt[k] += int'(req_ready_o[k] && vld[k]);
        if (busy_o && !busy_prev) begin
            b_start = cyc;
            reads   = 0;
        end
        if (stb_o && !stb_prev && !we_o) reads++;
        if (!busy_o && busy_prev) begin
            last_len   = cyc - b_start + 1;
            last_reads = reads;
        end

        if (rst_now) begin
            if (m_active) rq[m_gidx].push_front(m_item);
            m_active = 1'b0; m_stb = 1'b0; m_gap = 1'b0; m_wr = 1'b0;
            m_ptr = 0; m_lock = 1'b0;
        end else if (sel >= 0) begin
            m_item   = rq[sel].pop_front();
            m_active = 1'b1; m_gidx = sel; m_wr = 1'b0; m_stb = 1'b1; m_gap = 1'b0;
        end else if (m_stb && ack) begin
            if (!m_wr) begin
                m_wr  = !busy_rsp;
                m_gap = 1'b1;
                m_stb = 1'b0;
            end else begin
                wlog.push_back(m_gidx);
                blog.push_back(m_item.b);
                m_active = 1'b0; m_stb = 1'b0; m_wr = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
                if (m_item.last) begin
                    m_lock = 1'b0;
                    m_ptr  = (m_gidx + 1) % N;
                end else begin
                    m_lock     = 1'b1;
                    m_lock_idx = m_gidx;
                end
`else
                m_ptr = (m_gidx + 1) % N;
`endif
            end
        end else if (m_gap) begin
            m_stb = 1'b1;
            m_gap = 1'b0;
        end
        stb_prev  = stb_o;
        ack_prev  = ack;
        busy_prev = busy_o;
    endtask

    function automatic int pending();
        int p = 0;
        for (int k = 0; k < N; k++) p += rq[k].size();
        return p;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while ((pending() > 0 || m_active) && n < budget) begin
            tick();
            n++;
        end
        tick();
        check_eq("drain_done", 64'(pending() == 0 && !m_active), 64'd1);
    endtask

    task automatic do_reset();
        rst_now = 1'b1;
        tick();
        tick();
        rst_now = 1'b0;
    endtask

    task automatic clear_logs();
        wlog.delete();
        blog.delete();
        for (int k = 0; k < N; k++) rdy_cnt[k] = 0;
    endtask

    initial begin
        logic [7:0] exp_b [N][$];
        logic [7:0] b;
        int         n;
        int         k;

        // Reset state
        do_reset();
        check_eq("reset_outputs",
                 64'({req_ready_o, grant_o, busy_o, stb_o, we_o, addr_o, data_o}), 64'h0);

        // Single byte, UART idle on first poll
        clear_logs();
        rq[0].push_back('{1'b1, 8'hA5});
        drain(50);
        check_eq("t1_writes", 64'(wlog.size()), 64'd1);
        check_eq("t1_owner", 64'(wlog.size() > 0 ? wlog[0] : -1), 64'd0);
        check_eq("t1_byte", 64'(blog.size() > 0 ? blog[0] : 8'h00), 64'hA5);
        check_eq("t1_ready_pulses", 64'(rdy_cnt[0]), 64'd1);
        check_eq("t1_len", 64'(last_len), 64'd6);
        check_eq("t1_reads", 64'(last_reads), 64'd1);

        // Three busy polls before idle
        clear_logs();
        busy_q = '{1, 1, 1, 0};
        rq[0].push_back('{1'b1, 8'h5A});
        drain(80);
        check_eq("t2_reads", 64'(last_reads), 64'd4);
        check_eq("t2_len", 64'(last_len), 64'd15);
        check_eq("t2_byte", 64'(blog.size() > 0 ? blog[0] : 8'h00), 64'h5A);

        // Both requesters continuously valid: strict alternation from requester 0
        do_reset();
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            rq[0].push_back('{1'b1, 8'(8'h10 + i)});
            rq[1].push_back('{1'b1, 8'(8'h20 + i)});
        end
        drain(200);
        check_eq("t3_writes", 64'(wlog.size()), 64'd8);
        for (int i = 0; i < 8 && i < wlog.size(); i++) check_eq("t3_order", 64'(wlog[i]), 64'(i % 2));

`ifdef UART_TX_ARB_LOCK_EN
        // Locked message from requester 1 runs to completion before requester 0
        do_reset();
        rq[0].push_back('{1'b1, 8'h01});
        drain(50);
        clear_logs();
        rq[1].push_back('{1'b0, 8'h11});
        rq[1].push_back('{1'b0, 8'h22});
        rq[1].push_back('{1'b1, 8'h33});
        rq[0].push_back('{1'b1, 8'h44});
        drain(200);
        check_eq("lock_writes", 64'(wlog.size()), 64'd4);
        if (wlog.size() == 4) begin
            check_eq("lock_order", 64'({8'(wlog[0]), 8'(wlog[1]), 8'(wlog[2]), 8'(wlog[3])}),
                     64'h01010100);
            check_eq("lock_bytes", 64'({blog[0], blog[1], blog[2], blog[3]}), 64'h11223344);
        end
`endif

        // Reset while the data write strobe is up
        do_reset();
        clear_logs();
        rq[1].push_back('{1'b1, 8'h3C});
        n = 0;
        while (!(stb_o && we_o) && n < 50) begin
            tick();
            n++;
        end
        check_eq("t5_reached_wr", 64'(stb_o && we_o), 64'd1);
        rst_now = 1'b1;
        tick();
        rst_now = 1'b0;
        tick();
        check_eq("t5_outputs_zero", 64'({grant_o, busy_o, stb_o, we_o, addr_o, data_o}), 64'h0);
        drain(50);
        check_eq("t5_writes", 64'(wlog.size()), 64'd1);
        check_eq("t5_byte", 64'(blog.size() > 0 ? blog[0] : 8'h00), 64'h3C);
        check_eq("t5_ready_pulses", 64'(rdy_cnt[1]), 64'd2);

        // Randomized traffic with gaps, busy polls and slave wait states
        do_reset();
        clear_logs();
        gate_pct = 70;
        busy_pct = 30;
        max_wait = 2;
        for (k = 0; k < N; k++) begin
            for (int i = 0; i < 15; i++) begin
                b = 8'($urandom());
                rq[k].push_back('{(i == 14) ? 1'b1 : 1'($urandom()), b});
                exp_b[k].push_back(b);
            end
        end
        drain(4000);
        check_eq("t6_writes", 64'(wlog.size()), 64'd30);
        for (int i = 0; i < wlog.size(); i++) begin
            k = wlog[i];
            if (exp_b[k].size() > 0) check_eq("t6_stream", 64'(blog[i]), 64'(exp_b[k].pop_front()));
            else check_eq("t6_extra_write", 64'(k), 64'hFFFF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
